// File: rtl/precision_packer.sv
// precision_packer: packs accepted trace vectors lane-wise into N-lane words,
// with per-chain element count and runtime sub-word precision (1/2/4 slices).
module precision_packer #(
  parameter int N                     = 8,
  parameter int M                     = 2,
  parameter int DATA_WIDTH            = 32,
  parameter int MAX_CHAINS            = 4,
  parameter int MAX_PRECISION         = 4,
  parameter int PERSONAL_CONFIG_ID    = 0,
  parameter int INITIAL_FIRMWARE      = 0,
  parameter int INITIAL_FIRMWARE_COND = 0,
  parameter int INITIAL_PRECISION     = 0,
  localparam int CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tracing,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [1:0]                   eof_in,
  input  logic [1:0]                   bof_in,
  input  logic [CHW-1:0]               chainId_in,
  input  logic                         flush,
  input  logic [7:0]                   configId,
  input  logic [7:0]                   configData,
  input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
  output logic                         valid_out,
  input  logic                         ready_in
);
  localparam int CW       = $clog2(N);
  localparam int LOG_MAXP = $clog2(MAX_PRECISION);
  localparam int SW       = (LOG_MAXP > 0) ? LOG_MAXP : 1;
  localparam int PLW      = (LOG_MAXP > 0) ? $clog2(LOG_MAXP + 1) : 1;

  typedef logic [CW:0]                  len_t;
  typedef logic [SW-1:0]                sl_t;
  typedef logic [PLW-1:0]               pl_t;
  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  localparam len_t       N_L        = len_t'(N);
  localparam len_t       M_L        = len_t'(M);
  localparam logic [7:0] LOG_MAXP_B = 8'(LOG_MAXP);
  localparam logic [7:0] PID        = 8'(PERSONAL_CONFIG_ID);

  // config tables, one byte per chain
  logic [MAX_CHAINS-1:0][7:0] cond_tab, fw_tab, prec_tab;
  logic [7:0]                 byte_cnt;

  // packing state
  vec_t          buf_q, buf_n, wr_buf, emit_data;
  logic [CW-1:0] cnt, cnt_n;
  sl_t           s, s_n;
  pl_t           buf_plog, plog_n;
  logic          pending_full, pend_n;

  // decoded per-chain view of the current beat
  logic [7:0] fw, cnd, pc, status;
  logic       commit, cond_ok, out_free, accept, buf_empty, restart, emit;
  len_t       len, cnt_ext, wr_base;
  pl_t        plog;
  sl_t        p_m1, wr_slice;

  // Decode the selected chain's tables and evaluate the accept filter.
  always_comb begin
    fw      = fw_tab[chainId_in];
    cnd     = cond_tab[chainId_in];
    pc      = prec_tab[chainId_in];
    commit  = (fw < 8'd3);
    len     = (fw == 8'd0) ? N_L : (fw == 8'd1) ? M_L : len_t'(1);
    // out-of-range precision codes fall back to one slice per word
    plog    = (pc <= LOG_MAXP_B) ? pl_t'(pc) : '0;
    p_m1    = sl_t'((1 << plog) - 1);
    status  = {~bof_in[1], bof_in[1], ~eof_in[1], eof_in[1],
               ~bof_in[0], bof_in[0], ~eof_in[0], eof_in[0]};
    // any selected term passing lets the beat through; empty mask always passes
    cond_ok = (cnd == 8'd0) || ((cnd & status) != 8'd0);
    out_free  = ~valid_out | ready_in;
    ready_out = out_free & ~flush & ~pending_full;
    accept    = valid_in & ready_out & tracing & commit & cond_ok;
    buf_empty = (cnt == '0) && (s == '0);
    cnt_ext   = {1'b0, cnt};
    // overflow or precision change: the old buffer goes out whole, new data starts fresh
    restart   = accept & ~buf_empty & (((cnt_ext + len) > N_L) | (plog != buf_plog));
    wr_base   = restart ? '0 : cnt_ext;
    wr_slice  = restart ? '0 : s;
  end

  // Per-lane slice insertion: each lane picks its element and merges its top W bits.
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam len_t LANE_IDX = len_t'(g);
    logic [DATA_WIDTH-1:0] elem, top, mask, base_val, nxt;
    len_t                  d;
    logic                  hit;
    int                    w, pos;

    // Write element (g - base) into slice wr_slice of this lane when it lands here.
    always_comb begin
      d        = LANE_IDX - wr_base;
      hit      = (LANE_IDX >= wr_base) && (d < len);
      elem     = vector_in[d[CW-1:0]];
      w        = DATA_WIDTH >> plog;
      pos      = w * int'(wr_slice);
      top      = elem >> (DATA_WIDTH - w);
      mask     = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - w);
      base_val = restart ? '0 : buf_q[g];
      nxt      = base_val;
      if (accept && hit) nxt = (base_val & ~(mask << pos)) | (top << pos);
    end
    assign wr_buf[g] = nxt;
  end

  // Next-state for buffer/counters and emit decision.
  always_comb begin
    buf_n     = buf_q;
    cnt_n     = cnt;
    s_n       = s;
    plog_n    = buf_plog;
    pend_n    = pending_full;
    emit      = 1'b0;
    emit_data = buf_q;
    if (pending_full) begin
      // a complete fresh buffer waits for the output register to free up
      if (out_free) begin
        emit   = 1'b1;
        buf_n  = '0;
        pend_n = 1'b0;
        cnt_n  = '0;
        s_n    = '0;
      end
    end else if (accept) begin
      plog_n = plog;
      if (restart) begin
        emit  = 1'b1;
        buf_n = wr_buf;
        if (len == N_L) begin
          cnt_n = '0;
          if (plog == '0) begin
            pend_n = 1'b1;
            s_n    = '0;
          end else begin
            s_n = sl_t'(1);
          end
        end else begin
          cnt_n = len[CW-1:0];
          s_n   = '0;
        end
      end else if ((cnt_ext + len) == N_L) begin
        cnt_n = '0;
        if (s == p_m1) begin
          emit      = 1'b1;
          emit_data = wr_buf;
          buf_n     = '0;
          s_n       = '0;
        end else begin
          buf_n = wr_buf;
          s_n   = s + sl_t'(1);
        end
      end else begin
        buf_n = wr_buf;
        cnt_n = cnt + len[CW-1:0];
      end
    end else if (flush & tracing & ~buf_empty & out_free) begin
      emit  = 1'b1;
      buf_n = '0;
      cnt_n = '0;
      s_n   = '0;
    end
  end

  // Packing state and output word register with valid/ready hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q        <= '0;
      cnt          <= '0;
      s            <= '0;
      buf_plog     <= '0;
      pending_full <= 1'b0;
      vector_out   <= '0;
      valid_out    <= 1'b0;
    end else begin
      buf_q        <= buf_n;
      cnt          <= cnt_n;
      s            <= s_n;
      buf_plog     <= plog_n;
      pending_full <= pend_n;
      if (emit) begin
        vector_out <= emit_data;
        valid_out  <= 1'b1;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

  // Configuration byte stream: cond, then firmware, then precision, MAX_CHAINS bytes each.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      cond_tab <= {MAX_CHAINS{8'(INITIAL_FIRMWARE_COND)}};
      fw_tab   <= {MAX_CHAINS{8'(INITIAL_FIRMWARE)}};
      prec_tab <= {MAX_CHAINS{8'(INITIAL_PRECISION)}};
    end else if (!tracing) begin
      if (configId == PID) begin
        if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
        for (int c = 0; c < MAX_CHAINS; c++) begin
          if (byte_cnt == 8'(c))                  cond_tab[c] <= configData;
          if (byte_cnt == 8'(c + MAX_CHAINS))     fw_tab[c]   <= configData;
          if (byte_cnt == 8'(c + 2 * MAX_CHAINS)) prec_tab[c] <= configData;
        end
      end else begin
        byte_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_precision_packer.sv
// Directed bench for precision_packer; expected words go into a queue and a
// monitor pops/compares them on every output handshake.
module tb_precision_packer;
  localparam int N  = 8;
  localparam int DW = 32;
  typedef logic [N-1:0][DW-1:0] vec_t;

  // byte order (index 11 down to 0): prec3..prec0, fw3..fw0, cond3..cond0
  localparam logic [11:0][7:0] CFG1 = {8'd0, 8'd1, 8'd2, 8'd0,
                                       8'd1, 8'd2, 8'd0, 8'd0,
                                       8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [11:0][7:0] CFG2 = {8'd0, 8'd1, 8'd2, 8'd0,
                                       8'd3, 8'd2, 8'd0, 8'd0,
                                       8'd0, 8'd0, 8'd0, 8'd1};

  logic       clk = 1'b0, rst_n = 1'b0, tracing = 1'b1, valid_in = 1'b0;
  logic       flush = 1'b0, ready_in = 1'b1, ready_out, valid_out;
  logic [1:0] eof_in = 2'b00, bof_in = 2'b00, chainId_in = 2'd0;
  logic [7:0] configId = 8'hFF, configData = 8'h00;
  vec_t       vector_in = '0, vector_out;

  int   checks = 0, errors = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  precision_packer #(
    .N(N), .M(2), .DATA_WIDTH(DW), .MAX_CHAINS(4), .MAX_PRECISION(4),
    .PERSONAL_CONFIG_ID(0), .INITIAL_FIRMWARE(0), .INITIAL_FIRMWARE_COND(0),
    .INITIAL_PRECISION(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .ready_out(ready_out), .eof_in(eof_in), .bof_in(bof_in),
    .chainId_in(chainId_in), .flush(flush), .configId(configId),
    .configData(configData), .vector_in(vector_in), .vector_out(vector_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  // monitor: a word is consumed at the next edge when valid_out & ready_in
  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_out && ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got=%h", vector_out);
        end else begin
          e = exp_q.pop_front();
          if (vector_out !== e) begin
            errors++;
            $display("FAIL word got=%h exp=%h", vector_out, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] b);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = b + 32'(i);
    return v;
  endfunction

  function automatic vec_t fill(input logic [31:0] x);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = x;
    return v;
  endfunction

  // present one beat and hold it until the edge where ready_out lets it in
  task automatic send(input vec_t v, input int ch, input logic [1:0] eof = 2'b00);
    int t;
    chainId_in = 2'(ch);
    vector_in  = v;
    eof_in     = eof;
    valid_in   = 1'b1;
    t = 0;
    while (!ready_out && t < 50) begin
      tick();
      t++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=ready_out_low exp=ready_out_high");
    end
    tick();
    valid_in = 1'b0;
    eof_in   = 2'b00;
  endtask

  task automatic cfg(input logic [11:0][7:0] b);
    tracing = 1'b0;
    for (int k = 0; k < 12; k++) begin
      configId   = 8'h00;
      configData = b[k];
      tick();
    end
    configId = 8'hFF;
    tick();
    tracing = 1'b1;
  endtask

  initial begin : stim
    vec_t e;
    // reset
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_valid", valid_out, 0);
    chk("reset_vector", vector_out, 0);
    chk("reset_ready", ready_out, 1);

    // INITIAL tables: P=1, L=N
    exp_q.push_back(mk(32'h0));
    send(mk(32'h0), 0);
    chk("first_latency_valid", valid_out, 1);
    idle(2);

    cfg(CFG1);

    // chain 1: P=4, L=N, four beats -> one word
    exp_q.push_back(fill(32'h04030201));
    for (int k = 0; k < 4; k++) send(fill((32'(k + 1) << 24) | 32'h00ABCDEF), 1);
    idle(2);

    // chain 2: P=2, L=1, sixteen beats -> one word
    for (int i = 0; i < N; i++)
      e[i] = ((32'hAA00 + 32'(i + 8)) << 16) | (32'hAA00 + 32'(i));
    exp_q.push_back(e);
    for (int j = 0; j < 16; j++) begin
      vector_in = fill(32'hDEADBEEF);
      e = vector_in;
      e[0] = 32'hAA000000 + (32'(j) << 16) + 32'h1234;
      send(e, 2);
    end
    idle(2);

    // overflow: two L=M beats then an L=N beat -> partial word, then pending full word
    e = '0;
    e[0] = 32'h11110000; e[1] = 32'h11110001; e[2] = 32'h22220000; e[3] = 32'h22220001;
    exp_q.push_back(e);
    exp_q.push_back(mk(32'h33330000));
    send(mk(32'h11110000), 3);
    send(mk(32'h22220000), 3);
    send(mk(32'h33330000), 0);
    chk("pending_ready_low", ready_out, 0);
    idle(3);
    chk("pending_drained_ready", ready_out, 1);

    // backpressure
    ready_in = 1'b0;
    exp_q.push_back(mk(32'h44440000));
    send(mk(32'h44440000), 0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready_low", ready_out, 0);
      chk("bp_valid_held", valid_out, 1);
      chk("bp_vector_stable", vector_out, mk(32'h44440000));
      tick();
    end
    ready_in = 1'b1;
    tick();
    chk("bp_release_ready", ready_out, 1);

    // flush a partial buffer, then flush an empty one (no word expected)
    e = '0;
    e[0] = 32'h77770000; e[1] = 32'h77770001;
    exp_q.push_back(e);
    send(mk(32'h77770000), 3);
    flush = 1'b1;
    #1;
    chk("flush_ready_low", ready_out, 0);
    tick();
    flush = 1'b0;
    chk("flush_emit_valid", valid_out, 1);
    idle(2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(4);
    chk("empty_flush_no_valid", valid_out, 0);

    // precision change P=1 -> P=4 with a non-empty buffer
    e = '0;
    e[0] = 32'h66660000; e[1] = 32'h66660001;
    exp_q.push_back(e);
    exp_q.push_back(fill(32'h13121110));
    send(mk(32'h66660000), 3);
    for (int k = 0; k < 4; k++) send(fill((32'(16 + k) << 24) | 32'h00FFFFFF), 1);
    idle(2);

    // condition mask on chain 0 (eof[0]) and no-commit firmware on chain 3
    cfg(CFG2);
    exp_q.push_back(mk(32'h88880000));
    send(mk(32'h99990000), 0, 2'b10);
    send(mk(32'hBBBB0000), 3);
    send(mk(32'h88880000), 0, 2'b01);
    idle(2);

    // reset in the middle of a pack: buffer discarded, tables back to INITIAL
    send(fill(32'h12345678), 2);
    send(fill(32'h12345678), 2);
    send(fill(32'h12345678), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_valid", valid_out, 0);
    chk("midreset_vector", vector_out, 0);
    exp_q.push_back(mk(32'h55550000));
    send(mk(32'h55550000), 2);
    idle(5);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
